bench_result_uart_tx: RTL



---
 rtl/bench_result_uart_tx.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/bench_result_uart_tx.sv
// Snapshots the four bench timing results and sends them as ASCII hex lines over UART 8N1.
// Optional macro BENCH_TX_WINNER_EN appends a "W:k" line naming the smallest result.
module bench_result_uart_tx #(
    parameter int CLK_HZ = 125000000,
    parameter int BAUD   = 115200,
    parameter int DIV    = CLK_HZ / BAUD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] t_cond0,
    input  logic [31:0] t_cond1,
    input  logic [31:0] t_cond2,
    input  logic [31:0] t_cond3,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int BW = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

`ifdef BENCH_TX_WINNER_EN
    localparam logic [2:0] LAST_LINE = 3'd4;
    localparam logic [3:0] LAST_POS  = 4'd4;
`else
    localparam logic [2:0] LAST_LINE = 3'd3;
    localparam logic [3:0] LAST_POS  = 4'd11;
`endif

    logic [2:0]    state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [2:0]    line;
    logic [3:0]    pos;
    logic [31:0]   snap [4];

    logic          baud_end;
    logic          last_byte;
    logic [7:0]    cur_byte;
    logic          tx_nxt;
    logic [31:0]   word;
    logic [2:0]    nsel;
    logic [3:0]    nib;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h37 + {4'd0, n});
    endfunction

`ifdef BENCH_TX_WINNER_EN
    logic [1:0]  win_k;
    logic [31:0] win_min;

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        win_k   = 2'd0;
        win_min = snap[0];
        for (int i = 1; i < 4; i++) begin
            if (snap[i] < win_min) begin
                win_min = snap[i];
                win_k   = 2'(i);
            end
        end
    end
`endif

    assign baud_end  = (baud_cnt == BW'(DIV - 1));
    assign last_byte = (line == LAST_LINE) && (pos == LAST_POS);
    assign word      = snap[line[1:0]];
    assign nsel      = 3'(4'd9 - pos);
    assign nib       = word[{nsel, 2'b00} +: 4];

    // Byte is chosen from (line, pos) so the next one is ready the moment STOP ends.
    always_comb begin
        cur_byte = 8'h0A;
`ifdef BENCH_TX_WINNER_EN
        if (line == 3'd4) begin
            case (pos)
                4'd0:    cur_byte = 8'h57;
                4'd1:    cur_byte = 8'h3A;
                4'd2:    cur_byte = 8'h30 + {6'd0, win_k};
                4'd3:    cur_byte = 8'h0D;
                default: cur_byte = 8'h0A;
            endcase
        end else
`endif
        begin
            case (pos)
                4'd0:    cur_byte = 8'h30 + {5'd0, line};
                4'd1:    cur_byte = 8'h3A;
                4'd10:   cur_byte = 8'h0D;
                4'd11:   cur_byte = 8'h0A;
                default: cur_byte = hex_ascii(nib);
            endcase
        end
    end

    always_comb begin
        case (state)
            S_START: tx_nxt = 1'b0;
            S_DATA:  tx_nxt = cur_byte[bit_cnt];
            default: tx_nxt = 1'b1;
        endcase
    end

    // tx is registered from the current state, so the line lags the FSM by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            line     <= '0;
            pos      <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            for (int i = 0; i < 4; i++) snap[i] <= '0;
        end else begin
            tx   <= tx_nxt;
            done <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start && !done) begin
                        snap[0]  <= t_cond0;
                        snap[1]  <= t_cond1;
                        snap[2]  <= t_cond2;
                        snap[3]  <= t_cond3;
                        busy     <= 1'b1;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        line     <= '0;
                        pos      <= '0;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            state   <= S_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (last_byte) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_START;
                            if (pos == 4'd11) begin
                                pos  <= '0;
                                line <= line + 1'b1;
                            end else begin
                                pos <= pos + 1'b1;
                            end
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
